temporal_window_filter: RTL and testbench
=========================================

# temporal_window_filter

Parametrised race-logic window filter for the filter stage of the spiking column datapath. Each gamma cycle it timestamps the first spike on every input channel and on two select lines, and forwards only the spikes whose arrival time falls inside a runtime-selectable temporal window. Supports rising-edge (level-hold) and fixed-width pulse spike coding. It also reports a per-gamma-cycle count of passed spikes.

## Interface
- GAMMA_CYCLE_WIDTH, 16: cycles per gamma cycle (≥4); phase width PW = $clog2(GAMMA_CYCLE_WIDTH)
- NUM_INPUTS, 16: number of spike channels
- PULSE_CODING, 0: 0 = rising-edge coding, 1 = pulse coding
- PULSE_WIDTH, 8: output pulse length in cycles when PULSE_CODING=1 (≥1)
- aclk  input  1  clock
- grst  input  1  reset; synchronous, active-high
- inputs  input  NUM_INPUTS  spike inputs
- sel_greater  input  1  lower window bound spike
- sel_lesser  input  1  upper window bound spike
- mode  input  2  00 pass-all, 01 greater-only, 10 lesser-only, 11 window
- y  output  NUM_INPUTS  filtered spikes, same coding as inputs
- phase  output  PW  current gamma phase
- count_out  output  $clog2(NUM_INPUTS+1)  spikes passed in the last completed gamma cycle
- count_valid  output  1  one-cycle strobe: count_out updated

## Operation
- Phase counter: 0..GAMMA_CYCLE_WIDTH-1, +1 per cycle, wraps to 0. Phase GAMMA_CYCLE_WIDTH-1 is the guard slot.
- Edge detect on inputs, sel_greater, sel_lesser: event = sampled high AND previous sample low; previous-sample registers update every cycle (including the guard slot), reset to 0. A line held high across the wrap produces no event in the new gamma cycle.
- First-spike only: per channel and per select line, only the first event in a gamma cycle counts; later events are ignored until the guard slot.
- Event at phase p on channel i passes iff all conditions enabled by mode hold:
  - greater (mode[0]): a sel_greater event has occurred at phase ≤ p. A same-cycle tie passes.
  - lesser (mode[1]): no sel_lesser event has occurred at phase ≤ p. A same-cycle tie blocks.
- Passed spike on channel i:
  - rising coding: y[i] goes high and holds until the guard slot.
  - pulse coding: y[i] goes high for PULSE_WIDTH cycles, truncated at the guard slot. Each channel has its own down-counter.
- pass_count accumulator: adds the popcount of passed events each cycle.
- Guard slot, on the posedge where phase == GAMMA_CYCLE_WIDTH-1:
  - events sampled in this slot are dropped;
  - y, all first-spike flags, the select-seen flags and the pulse counters are cleared;
  - count_out <= pass_count, count_valid <= 1, pass_count <= 0;
  - mode is latched for the next gamma cycle. mode is also latched during reset; mode changes mid-cycle have no effect.

## Timing
- Reset values (any cycle with grst=1): phase=0, y=0, count_out=0, count_valid=0, all flags, counters and previous-sample registers 0; mode latched.
- Reset mid-gamma: all state is abandoned with no count_valid strobe. The first posedge with grst=0 samples phase 0.
- Latency: an event sampled at the posedge with phase=p makes y[i] visible from the next cycle (phase p+1) onward.
- count_valid is high for exactly the cycle with phase=0 following each guard slot. count_out holds its value until the next guard slot.
- Simultaneous events: any number of channels may spike in one cycle. All are evaluated against the same select state, including same-cycle select events.
- count_out maximum is NUM_INPUTS. The accumulator width is $clog2(NUM_INPUTS+1), with no wrap.

## Test plan
- Pass-all, rising coding, mode=00: inputs[3] edge sampled at phase 2 -> y[3] high during phases 3..15, 0 at next phase 0; count_valid=1 with count_out=1.
- Window, mode=11: sel_greater at phase 2, sel_lesser at phase 5; input edges at phases 1/2/4/5/7 on channels 10/6/8/4/15 -> only y[6] (rising at phase 3) and y[8] (rising at phase 5) assert; count_out=2.
- Pulse coding, PULSE_WIDTH=4, mode=00: ch0 pulses at phases 2 and 8 -> y[0] high phases 3..6 only. ch1 pulse at phase 13 -> y[1] high phases 14..15, truncated. count_out=2.
- Boundary: all 16 inputs edge at phase 0 -> count_out=16. Edge at phase 15 -> dropped, no y. An input held high from phase 10 into the next gamma cycle -> no event in that next cycle.
- Mode latch: mode switched from 00 to 01 at phase 6 -> behaviour stays pass-all this gamma cycle. Next cycle, an input edge with no sel_greater spike -> blocked, count_out=0.
- Reset mid-gamma: grst at phase 7 with y[3]=1 -> next cycle y=0 and phase=0. No count_valid strobe until a full gamma cycle completes.

Source files
------------

// File: rtl/temporal_window_filter.sv
`default_nettype none
// ============================================================================
// Module      : temporal_window_filter
// Description : Race-logic temporal window filter. Once per gamma cycle it
//               timestamps the first rising edge on every spike channel and
//               on the two select lines. A channel's spike is forwarded only
//               if its arrival phase lies inside the window chosen by mode.
//               It also reports how many spikes passed in each gamma cycle.
// Ports       : aclk, grst           - clock, synchronous active-high reset
//               inputs[N]            - spike channels
//               sel_greater          - lower window bound spike
//               sel_lesser           - upper window bound spike
//               mode[2]              - 00 all, 01 greater, 10 lesser, 11 window
//               y[N]                 - filtered spikes (input coding)
//               phase[PW]            - current gamma phase
//               count_out[CW]        - spikes passed in last gamma cycle
//               count_valid          - one-cycle strobe, count_out updated
// Revision    : 1.0 - initial release
// ============================================================================
module temporal_window_filter #(
    parameter  int GAMMA_CYCLE_WIDTH = 16,
    parameter  int NUM_INPUTS        = 16,
    parameter  int PULSE_CODING      = 0,
    parameter  int PULSE_WIDTH       = 8,
    localparam int PW                = $clog2(GAMMA_CYCLE_WIDTH),
    localparam int CW                = $clog2(NUM_INPUTS + 1)
) (
    input  logic                  aclk,
    input  logic                  grst,
    input  logic [NUM_INPUTS-1:0] inputs,
    input  logic                  sel_greater,
    input  logic                  sel_lesser,
    input  logic [1:0]            mode,
    output logic [NUM_INPUTS-1:0] y,
    output logic [PW-1:0]         phase,
    output logic [CW-1:0]         count_out,
    output logic                  count_valid
);

    localparam logic [PW-1:0] GUARD_PHASE = PW'(GAMMA_CYCLE_WIDTH - 1);

    logic [PW-1:0]         phase_q, phase_d;
    logic [NUM_INPUTS-1:0] in_prev_q;
    logic [NUM_INPUTS-1:0] fired_q, fired_d;
    logic                  sg_prev_q, sl_prev_q;
    logic                  sg_seen_q, sg_seen_d;
    logic                  sl_seen_q, sl_seen_d;
    logic [1:0]            mode_q;
    logic [CW-1:0]         pass_count_q, pass_count_d;
    logic [CW-1:0]         count_out_q, count_out_d;
    logic                  count_valid_q, count_valid_d;

    logic                  w_guard;
    logic [NUM_INPUTS-1:0] w_ev;
    logic [NUM_INPUTS-1:0] w_first;
    logic [NUM_INPUTS-1:0] w_pass;
    logic                  w_sg_ev, w_sl_ev;
    logic                  w_greater_ok, w_lesser_ok;
    logic [CW-1:0]         w_pass_cnt;

    // Event detection and window decision
    always_comb begin
        w_guard = (phase_q == GUARD_PHASE);
        w_ev    = inputs & ~in_prev_q;
        w_sg_ev = sel_greater & ~sg_prev_q;
        w_sl_ev = sel_lesser  & ~sl_prev_q;
        w_first = w_ev & ~fired_q;
        // Same-cycle select events count as already seen: a greater tie
        // passes, a lesser tie blocks.
        w_greater_ok = ~mode_q[0] | sg_seen_q | w_sg_ev;
        w_lesser_ok  = ~mode_q[1] | ~(sl_seen_q | w_sl_ev);
        w_pass       = '0;
        if (!w_guard && w_greater_ok && w_lesser_ok) begin
            w_pass = w_first;
        end
        w_pass_cnt = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_pass_cnt = w_pass_cnt + CW'(w_pass[i]);
        end
    end

    // Next-state logic
    always_comb begin
        phase_d       = phase_q + PW'(1);
        fired_d       = fired_q | w_ev;
        sg_seen_d     = sg_seen_q | w_sg_ev;
        sl_seen_d     = sl_seen_q | w_sl_ev;
        pass_count_d  = pass_count_q + w_pass_cnt;
        count_out_d   = count_out_q;
        count_valid_d = 1'b0;
        if (w_guard) begin
            phase_d       = '0;
            fired_d       = '0;
            sg_seen_d     = 1'b0;
            sl_seen_d     = 1'b0;
            pass_count_d  = '0;
            count_out_d   = pass_count_q;
            count_valid_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            phase_q       <= '0;
            in_prev_q     <= '0;
            sg_prev_q     <= 1'b0;
            sl_prev_q     <= 1'b0;
            fired_q       <= '0;
            sg_seen_q     <= 1'b0;
            sl_seen_q     <= 1'b0;
            pass_count_q  <= '0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
            mode_q        <= mode;
        end else begin
            phase_q       <= phase_d;
            in_prev_q     <= inputs;
            sg_prev_q     <= sel_greater;
            sl_prev_q     <= sel_lesser;
            fired_q       <= fired_d;
            sg_seen_q     <= sg_seen_d;
            sl_seen_q     <= sl_seen_d;
            pass_count_q  <= pass_count_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
            // Mode only changes at a gamma boundary so the whole cycle is
            // judged against one window definition.
            if (w_guard) begin
                mode_q <= mode;
            end
        end
    end

    // Output coding
    generate
        if (PULSE_CODING != 0) begin : g_pulse
            localparam int            PCW        = $clog2(PULSE_WIDTH + 1);
            localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_WIDTH);
            for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
                logic [PCW-1:0] pcnt_q;
                always_ff @(posedge aclk) begin
                    if (grst || w_guard) begin
                        pcnt_q <= '0;
                    end else if (w_pass[i]) begin
                        pcnt_q <= PULSE_LOAD;
                    end else if (pcnt_q != '0) begin
                        pcnt_q <= pcnt_q - PCW'(1);
                    end
                end
                assign y[i] = (pcnt_q != '0);
            end
        end else begin : g_rise
            logic [NUM_INPUTS-1:0] y_q;
            always_ff @(posedge aclk) begin
                if (grst || w_guard) begin
                    y_q <= '0;
                end else begin
                    y_q <= y_q | w_pass;
                end
            end
            assign y = y_q;
        end
    endgenerate

    assign phase       = phase_q;
    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_temporal_window_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_temporal_window_filter
// Description : Self-checking bench for temporal_window_filter. Drives a
//               rising-coded and a pulse-coded instance with the same
//               directed stimulus, compares both against a timestamp-based
//               model every cycle, and pins key points with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temporal_window_filter;

    localparam int G    = 16;
    localparam int N    = 16;
    localparam int PWID = 4;

    logic         aclk        = 1'b0;
    logic         grst        = 1'b1;
    logic [N-1:0] inputs      = '0;
    logic         sel_greater = 1'b0;
    logic         sel_lesser  = 1'b0;
    logic [1:0]   mode        = 2'b00;

    logic [N-1:0] y_r, y_p;
    logic [3:0]   ph_r, ph_p;
    logic [4:0]   co_r, co_p;
    logic         cv_r, cv_p;

    always #5 aclk = ~aclk;

    temporal_window_filter #(
        .GAMMA_CYCLE_WIDTH(G), .NUM_INPUTS(N), .PULSE_CODING(0), .PULSE_WIDTH(8)
    ) u_rise (
        .aclk(aclk), .grst(grst), .inputs(inputs), .sel_greater(sel_greater),
        .sel_lesser(sel_lesser), .mode(mode), .y(y_r), .phase(ph_r),
        .count_out(co_r), .count_valid(cv_r)
    );

    temporal_window_filter #(
        .GAMMA_CYCLE_WIDTH(G), .NUM_INPUTS(N), .PULSE_CODING(1), .PULSE_WIDTH(PWID)
    ) u_pulse (
        .aclk(aclk), .grst(grst), .inputs(inputs), .sel_greater(sel_greater),
        .sel_lesser(sel_lesser), .mode(mode), .y(y_p), .phase(ph_p),
        .count_out(co_p), .count_valid(cv_p)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: arrival timestamps per gamma cycle ----------------
    int           m_phase = 0;
    logic [N-1:0] m_prev  = '0;
    logic         m_pg = 1'b0, m_pl = 1'b0;
    int           first_t [N];
    int           pass_t  [N];
    int           t_g = -1, t_l = -1;
    logic [1:0]   m_mode = 2'b00;
    int           m_count_out = 0;
    logic         m_valid = 1'b0;

    task automatic model_step();
        logic [N-1:0] ev;
        logic g_ev, l_ev;
        int np;
        bit ok_g, ok_l;
        if (grst) begin
            m_phase = 0;
            for (int i = 0; i < N; i++) begin first_t[i] = -1; pass_t[i] = -1; end
            t_g = -1; t_l = -1;
            m_mode = mode; m_count_out = 0; m_valid = 1'b0;
            m_prev = '0; m_pg = 1'b0; m_pl = 1'b0;
        end else begin
            ev   = inputs & ~m_prev;
            g_ev = sel_greater & ~m_pg;
            l_ev = sel_lesser & ~m_pl;
            if (m_phase == G - 1) begin
                np = 0;
                for (int i = 0; i < N; i++) if (pass_t[i] >= 0) np++;
                m_count_out = np;
                m_valid = 1'b1;
                for (int i = 0; i < N; i++) begin first_t[i] = -1; pass_t[i] = -1; end
                t_g = -1; t_l = -1;
                m_mode = mode;
            end else begin
                m_valid = 1'b0;
                if (g_ev && t_g < 0) t_g = m_phase;
                if (l_ev && t_l < 0) t_l = m_phase;
                for (int i = 0; i < N; i++) begin
                    if (ev[i] && first_t[i] < 0) begin
                        first_t[i] = m_phase;
                        ok_g = !m_mode[0] || (t_g >= 0 && t_g <= m_phase);
                        ok_l = !m_mode[1] || !(t_l >= 0 && t_l <= m_phase);
                        if (ok_g && ok_l) pass_t[i] = m_phase;
                    end
                end
            end
            m_phase = (m_phase + 1) % G;
            m_prev = inputs; m_pg = sel_greater; m_pl = sel_lesser;
        end
    endtask

    always @(posedge aclk) model_step();

    task automatic compare_step();
        logic [N-1:0] exp_r, exp_p;
        for (int i = 0; i < N; i++) begin
            exp_r[i] = (pass_t[i] >= 0) && (pass_t[i] < m_phase);
            exp_p[i] = (pass_t[i] >= 0) && (m_phase > pass_t[i]) && (m_phase <= pass_t[i] + PWID);
        end
        check("model_y_rise",  y_r,  exp_r);
        check("model_y_pulse", y_p,  exp_p);
        check("model_phase_r", ph_r, m_phase);
        check("model_phase_p", ph_p, m_phase);
        check("model_count_r", co_r, m_count_out);
        check("model_count_p", co_p, m_count_out);
        check("model_valid_r", cv_r, m_valid);
        check("model_valid_p", cv_p, m_valid);
    endtask

    always @(negedge aclk) if (chk_en) compare_step();

    // Advance to the next negedge at which the current phase equals p.
    task automatic goto(input int p);
        int n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (m_phase != p && n < 3 * G);
        if (m_phase != p) check("goto_timeout", m_phase, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge aclk);
        chk_en = 1'b1;
        check("reset_y",     y_r,  0);
        check("reset_phase", ph_r, 0);
        check("reset_cv",    cv_r, 0);
        check("reset_cnt",   co_r, 0);
        grst = 1'b0;

        // A: pass-all, single edge
        goto(2);  inputs[3] = 1'b1;
        goto(3);  check("A_y3_rise", y_r, 16'h0008);
        goto(6);  inputs = '0;
        goto(10); mode = 2'b11;
        goto(15); check("A_y3_hold", y_r, 16'h0008);
        goto(0);  check("A_cv", cv_r, 1); check("A_cnt", co_r, 1); check("A_y_clear", y_r, 0);

        // B: window mode
        goto(1);  inputs[10] = 1'b1;
        goto(2);  inputs[6] = 1'b1; sel_greater = 1'b1;
        goto(3);  check("B_y6", y_r, 16'h0040);
        goto(4);  inputs[8] = 1'b1;
        goto(5);  inputs[4] = 1'b1; sel_lesser = 1'b1; check("B_y6_y8", y_r, 16'h0140);
        goto(7);  inputs[15] = 1'b1;
        goto(8);  check("B_window", y_r, 16'h0140);
        goto(12); inputs = '0; sel_greater = 1'b0; sel_lesser = 1'b0; mode = 2'b00;
        goto(0);  check("B_cnt", co_r, 2);

        // C: pulse coding
        goto(2);  inputs[0] = 1'b1;
        goto(3);  inputs[0] = 1'b0; check("C_p0_start", y_p, 16'h0001);
        goto(6);  check("C_p0_end", y_p, 16'h0001);
        goto(7);  check("C_p0_off", y_p, 16'h0000);
        goto(8);  inputs[0] = 1'b1;
        goto(9);  inputs[0] = 1'b0; check("C_p0_second_ignored", y_p, 16'h0000);
        goto(13); inputs[1] = 1'b1;
        goto(14); inputs[1] = 1'b0; check("C_p1", y_p, 16'h0002);
        goto(15); check("C_p1_hold", y_p, 16'h0002);
        goto(0);  check("C_p1_trunc", y_p, 16'h0000); check("C_cnt", co_r, 2);

        // D: all channels at phase 0
        inputs = '1;
        goto(1);  check("D_all", y_r, 16'hFFFF);
        goto(0);  check("D_cnt16", co_r, 16);

        // E: guard-slot edge dropped, hold across wrap
        goto(1);  inputs = '0;
        goto(10); inputs[2] = 1'b1;
        goto(15); inputs[5] = 1'b1;
        goto(0);  check("E_guard_drop", y_r, 0); check("E_cnt", co_r, 1);

        // F: held lines give no event; mid-cycle mode change ignored
        goto(5);  check("F_held_no_event", y_r, 0);
        goto(6);  mode = 2'b01;
        goto(7);  inputs = '0;
        goto(8);  inputs[9] = 1'b1;
        goto(9);  check("F_mode_unchanged", y_r, 16'h0200);
        goto(12); inputs = '0;
        goto(0);  check("F_cnt", co_r, 1);

        // G: greater-only with no select spike
        goto(3);  inputs[7] = 1'b1;
        goto(4);  check("G_blocked", y_r, 0);
        goto(6);  inputs = '0;
        goto(0);  check("G_cnt0", co_r, 0); check("G_cv", cv_r, 1);

        // H: reset mid-gamma
        goto(1);  sel_greater = 1'b1;
        goto(2);  inputs[3] = 1'b1;
        goto(3);  check("H_y3", y_r, 16'h0008);
        goto(7);  grst = 1'b1; inputs = '0; sel_greater = 1'b0; mode = 2'b00;
        @(negedge aclk);
        check("H_rst_y", y_r, 0); check("H_rst_phase", ph_r, 0); check("H_rst_cv", cv_r, 0);
        grst = 1'b0;
        goto(4);  inputs[1] = 1'b1;
        goto(5);  inputs = '0;
        goto(15); check("H_no_early_cv", cv_r, 0);
        goto(0);  check("H_cv", cv_r, 1); check("H_cnt", co_r, 1);
        @(negedge aclk);
        check("H_cv_one_cycle", cv_r, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
